// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one command byte
// (LSB first, odd parity, stop) on device clock falls, and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned CLK_FREQ_HZ      = 24000000,
    parameter int unsigned INHIBIT_US       = 120,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned XFER_TIMEOUT_US  = 2000,
    parameter int unsigned FILTER_LEN       = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       txDone,
    output logic       txErr,
    output logic       rxInhibit,
    input  logic       KBD_CLK,
    input  logic       KBD_DATA,
    output logic       kbdClkOe,
    output logic       kbdDataOe
);

    localparam int unsigned CYC_PER_US = CLK_FREQ_HZ / 1000000;
    localparam int unsigned N_INH      = CYC_PER_US * INHIBIT_US;
    localparam int unsigned N_ST       = CYC_PER_US * START_TIMEOUT_US;
    localparam int unsigned N_XF       = CYC_PER_US * XFER_TIMEOUT_US;
    localparam int unsigned N_MAX01    = (N_INH > N_ST) ? N_INH : N_ST;
    localparam int unsigned N_MAX      = (N_MAX01 > N_XF) ? N_MAX01 : N_XF;
    localparam int unsigned TW         = $clog2(N_MAX + 1);
    localparam int unsigned FW         = $clog2(FILTER_LEN + 1);
    localparam int unsigned BW         = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_DONE, S_ERR
    } state_t;

    logic [1:0]    clk_s_q;
    logic [1:0]    dat_s_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic          fall_q;

    state_t        state_q;
    logic [8:0]    frame_q;
    logic [BW-1:0] bit_q;
    logic [TW-1:0] timer_q;
    logic          ready_q;
    logic          done_q;
    logic          err_q;
    logic          inh_q;
    logic          clk_oe_q;
    logic          dat_oe_q;
    logic          fail_c;

    assign txReady   = ready_q;
    assign txDone    = done_q;
    assign txErr     = err_q;
    assign rxInhibit = inh_q;
    assign kbdClkOe  = clk_oe_q;
    assign kbdDataOe = dat_oe_q;

    // Pin synchronisers plus a stability filter on the clock; fall_q pulses on an accepted 1->0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
            fall_q  <= 1'b0;
        end else begin
            clk_s_q <= {clk_s_q[0], KBD_CLK};
            dat_s_q <= {dat_s_q[0], KBD_DATA};
            fall_q  <= 1'b0;
            if (clk_s_q[1] != filt_q) begin
                if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                    filt_q <= clk_s_q[1];
                    fcnt_q <= '0;
                    fall_q <= filt_q;
                end else begin
                    fcnt_q <= fcnt_q + FW'(1);
                end
            end else begin
                fcnt_q <= '0;
            end
        end
    end

    // Timeouts take priority over a coincident fall; a high data line at the ACK fall is a failure.
    always_comb begin
        fail_c = 1'b0;
        if (state_q == S_REQ && timer_q == TW'(N_ST - 1)) begin
            fail_c = 1'b1;
        end
        if ((state_q == S_SEND || state_q == S_ACK) && timer_q == TW'(N_XF - 1)) begin
            fail_c = 1'b1;
        end
        if (state_q == S_SEND && fall_q && bit_q == BW'(10) && dat_s_q[1]) begin
            fail_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            bit_q    <= '0;
            timer_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            inh_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else if (fail_c) begin
            state_q  <= S_ERR;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (txValid && ready_q) begin
                        frame_q  <= {~^txData, txData};
                        bit_q    <= '0;
                        timer_q  <= '0;
                        ready_q  <= 1'b0;
                        inh_q    <= 1'b1;
                        clk_oe_q <= 1'b1;
                        state_q  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (timer_q == TW'(N_INH - 1)) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b1;
                        timer_q  <= '0;
                        state_q  <= S_REQ;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_REQ: begin
                    if (fall_q) begin
                        dat_oe_q <= ~frame_q[0];
                        bit_q    <= BW'(1);
                        timer_q  <= '0;
                        state_q  <= S_SEND;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_SEND: begin
                    timer_q <= timer_q + TW'(1);
                    if (fall_q) begin
                        if (bit_q == BW'(10)) begin
                            state_q <= S_ACK;
                        end else if (bit_q == BW'(9)) begin
                            dat_oe_q <= 1'b0;
                            bit_q    <= bit_q + BW'(1);
                        end else begin
                            dat_oe_q <= ~frame_q[bit_q];
                            bit_q    <= bit_q + BW'(1);
                        end
                    end
                end
                S_ACK: begin
                    timer_q <= timer_q + TW'(1);
                    if (dat_s_q[1] && filt_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE, S_ERR: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    inh_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
